// File: rtl/modn_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
package modn_pkg;

    typedef enum logic [0:0] {ST_RUN, ST_DONE} modn_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/modn_next_val.sv
// Combinational next-count and terminal-step detection for the modulo-N counter.
module modn_next_val
    import modn_pkg::*;
#(
    parameter int unsigned MODULUS = 7,
    parameter int unsigned WIDTH   = $clog2(MODULUS),
    parameter bit          ONESHOT = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_count,
    output logic             terminal
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_W   = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Extra bit keeps the increment from aliasing when 2**WIDTH == MODULUS.
        sum        = {1'b0, count} + ONE_W;
        diff       = count - WIDTH'(1);
        next_count = count;
        terminal   = 1'b0;
        case (up_dn)
            DIR_UP: begin
                terminal   = (sum >= MOD_W);
                next_count = terminal ? (ONESHOT ? MAX_VAL : '0) : sum[WIDTH-1:0];
            end
            DIR_DN: begin
                terminal   = (count == '0);
                next_count = terminal ? (ONESHOT ? '0 : MAX_VAL) : diff;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with parallel load and optional one-shot stop.
// Define MODN_GRAY_EN to add the registered Gray-coded count output.
module modn_updown_counter
    import modn_pkg::*;
#(
    parameter int unsigned MODULUS = 7,
    parameter int unsigned WIDTH   = $clog2(MODULUS),
    parameter int unsigned INIT    = 0,
    parameter bit          ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
`ifdef MODN_GRAY_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    modn_state_t      state;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] count_d;
    logic             terminal;
    logic             load_ok;
    logic             step;

    modn_next_val #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH),
        .ONESHOT (ONESHOT)
    ) u_next_val (
        .count      (count),
        .up_dn      (up_dn),
        .next_count (step_val),
        .terminal   (terminal)
    );

    assign load_ok = ({1'b0, load_val} < MOD_W);
    assign step    = en && (state == ST_RUN);

    always_comb begin
        count_d = count;
        if (reset) begin
            count_d = INIT_VAL;
        end else if (load) begin
            // Out-of-range loads saturate so count never leaves 0..MODULUS-1.
            count_d = load_ok ? load_val : MAX_VAL;
        end else if (step) begin
            count_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        count <= count_d;
        if (reset) begin
            state    <= ST_RUN;
            tc       <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                state    <= ST_RUN;
                done     <= 1'b0;
                load_err <= !load_ok;
            end else if (step) begin
                tc <= terminal;
                if (ONESHOT && terminal) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

`ifdef MODN_GRAY_EN
    // Encoded from count_d so the Gray value lands in the same cycle as count.
    always_ff @(posedge clk) begin
        count_gray <= WIDTH'(bin2gray(32'(count_d)));
    end
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench: four counter configurations driven by shared stimulus, checked against an integer model.
module tb_modn_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [3:0] lv4;

    always #5 clk = ~clk;

    logic [2:0] c7, c_os, c8;
    logic [3:0] c10;
    logic       tc7, tc10, tc_os, tc8;
    logic       dn7, dn10, dn_os, dn8;
    logic       le7, le10, le_os, le8;
`ifdef MODN_GRAY_EN
    logic [2:0] g7, g_os, g8;
    logic [3:0] g10;
`endif

    modn_updown_counter #(.MODULUS(7), .WIDTH(3), .INIT(0), .ONESHOT(1'b0)) u_m7 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4[2:0]),
        .count(c7), .tc(tc7), .done(dn7),
`ifdef MODN_GRAY_EN
        .count_gray(g7),
`endif
        .load_err(le7));

    modn_updown_counter #(.MODULUS(10), .WIDTH(4), .INIT(5), .ONESHOT(1'b0)) u_m10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
        .count(c10), .tc(tc10), .done(dn10),
`ifdef MODN_GRAY_EN
        .count_gray(g10),
`endif
        .load_err(le10));

    modn_updown_counter #(.MODULUS(7), .WIDTH(3), .INIT(4), .ONESHOT(1'b1)) u_os (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4[2:0]),
        .count(c_os), .tc(tc_os), .done(dn_os),
`ifdef MODN_GRAY_EN
        .count_gray(g_os),
`endif
        .load_err(le_os));

    modn_updown_counter #(.MODULUS(8), .WIDTH(3), .INIT(0), .ONESHOT(1'b0)) u_m8 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4[2:0]),
        .count(c8), .tc(tc8), .done(dn8),
`ifdef MODN_GRAY_EN
        .count_gray(g8),
`endif
        .load_err(le8));

    // Reference model: one entry per instance (m7, m10, oneshot m7, m8).
    int mod_of[4]  = '{7, 10, 7, 8};
    int init_of[4] = '{0, 5, 4, 0};
    bit os_of[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    int mc[4];
    bit mtc[4], mdone[4], mlerr[4];

    int checks = 0;
    int errors = 0;

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            int m  = mod_of[i];
            int lv = (i == 1) ? int'(lv4) : int'(lv4) % 8;
            bit wrap;
            if (reset) begin
                mc[i] = init_of[i]; mtc[i] = 0; mdone[i] = 0; mlerr[i] = 0;
            end else if (load) begin
                mtc[i] = 0; mdone[i] = 0;
                if (lv < m) begin mc[i] = lv; mlerr[i] = 0; end
                else begin mc[i] = m - 1; mlerr[i] = 1; end
            end else if (en && !mdone[i]) begin
                wrap     = up_dn ? (mc[i] == m - 1) : (mc[i] == 0);
                mtc[i]   = wrap;
                mlerr[i] = 0;
                if (!wrap) mc[i] = up_dn ? mc[i] + 1 : mc[i] - 1;
                else if (os_of[i]) begin mdone[i] = 1; mc[i] = up_dn ? m - 1 : 0; end
                else mc[i] = up_dn ? 0 : m - 1;
            end else begin
                mtc[i] = 0; mlerr[i] = 0;
            end
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(int i, int cnt, logic t, logic d, logic le);
        chk($sformatf("u%0d.count", i), cnt, mc[i]);
        chk($sformatf("u%0d.tc", i), int'(t), int'(mtc[i]));
        chk($sformatf("u%0d.done", i), int'(d), int'(mdone[i]));
        chk($sformatf("u%0d.load_err", i), int'(le), int'(mlerr[i]));
`ifdef MODN_GRAY_EN
        chk($sformatf("u%0d.gray", i), gray_of(i), mc[i] ^ (mc[i] >> 1));
`endif
    endtask

`ifdef MODN_GRAY_EN
    function automatic int gray_of(int i);
        case (i)
            0: return int'(g7);
            1: return int'(g10);
            2: return int'(g_os);
            default: return int'(g8);
        endcase
    endfunction
`endif

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk_inst(0, int'(c7), tc7, dn7, le7);
        chk_inst(1, int'(c10), tc10, dn10, le10);
        chk_inst(2, int'(c_os), tc_os, dn_os, le_os);
        chk_inst(3, int'(c8), tc8, dn8, le8);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; lv4 = 4'd0;
        cycle(); cycle();
        chk("reset.m10_init", int'(c10), 5);

        // Up count with wraps.
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (16) cycle();

        // Load 0 together with en (load wins), then count down through the wrap.
        load = 1'b1; lv4 = 4'd0;
        cycle();
        chk("load_en.m7", int'(c7), 0);
        load = 1'b0; up_dn = 1'b0;
        cycle();
        chk("down_wrap.m7", int'(c7), 6);
        chk("down_wrap.tc", int'(tc7), 1);
        repeat (8) cycle();

        // In-range then out-of-range load on the MODULUS=10 instance.
        en = 1'b0; load = 1'b1; lv4 = 4'd9;
        cycle();
        chk("load9.count", int'(c10), 9);
        chk("load9.err", int'(le10), 0);
        lv4 = 4'd12;
        cycle();
        chk("load12.count", int'(c10), 9);
        chk("load12.err", int'(le10), 1);
        load = 1'b0;
        cycle();
        chk("load12.err_clear", int'(le10), 0);

        // One-shot from INIT=4 upward, then reload.
        reset = 1'b1;
        cycle();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (5) cycle();
        chk("oneshot.hold", int'(c_os), 6);
        chk("oneshot.done", int'(dn_os), 1);
        load = 1'b1; lv4 = 4'd2;
        cycle();
        chk("oneshot.reload", int'(c_os), 2);
        chk("oneshot.done_clr", int'(dn_os), 0);

        // Load with en, then reset mid-count.
        lv4 = 4'd3;
        cycle();
        chk("load3_en.count", int'(c7), 3);
        load = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        chk("mid_reset.m10", int'(c10), 5);
        reset = 1'b0;

        // Randomized traffic.
        repeat (400) begin
            reset = ($urandom_range(0, 49) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up_dn = 1'($urandom_range(0, 1));
            lv4   = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
